// File: rtl/mmio_bus_decoder_pkg.sv
// mmio_pkg: shared types and constants for the MMIO bus decoder.
// FSM state encoding, fixed peripheral slot numbers and the default
// width of the region index carved from the top address bits.
package mmio_pkg;

  // Default number of top address bits used as the region index
  localparam int MMIO_SEL_BITS = 2;

  // Peripheral slots in the default memory map (region index values)
  localparam int SLOT_DMEM   = 0;  // 0x0xxxxxxx .. 0x3xxxxxxx
  localparam int SLOT_LED    = 1;  // 0x4xxxxxxx .. 0x7xxxxxxx
  localparam int SLOT_SWITCH = 2;  // 0x8xxxxxxx .. 0xBxxxxxxx

  // Transaction engine states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mmio_state_e;

endpackage : mmio_pkg

// File: rtl/mmio_bus_decoder_region_decode.sv
// mmio_region_decode: combinational region decoder.
// Takes the region bits of an address (its top SEL_BITS bits) and produces
// the region index, a one-hot slave select and a mapped flag. Indices at or
// above NUM_SLAVES are unmapped and select nothing.
module mmio_region_decode
  import mmio_pkg::*;
#(
  parameter int SEL_BITS   = MMIO_SEL_BITS,
  parameter int NUM_SLAVES = 3
) (
  input  logic [SEL_BITS-1:0]   addr_hi_i,
  output logic [SEL_BITS-1:0]   idx_o,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  mapped_o
);

  assign idx_o    = addr_hi_i;
  assign mapped_o = (int'(addr_hi_i) < NUM_SLAVES);

  // One-hot select; stays all-zero for an unmapped index
  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(addr_hi_i) == i) sel_o[i] = 1'b1;
    end
  end

endmodule : mmio_region_decode

// File: rtl/mmio_bus_decoder.sv
// mmio_bus_decoder: registered MMIO transaction engine.
// Accepts one load/store at a time from the core, selects one peripheral
// by the top address bits, waits for that peripheral's ack and returns a
// single-cycle response carrying read data or an error flag.
// Optional build macro MMIO_DEC_TIMEOUT_EN adds an ACCESS-state watchdog
// that turns a missing ack into an error response after TIMEOUT_CYCLES.
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 3,
  parameter int SEL_BITS       = MMIO_SEL_BITS,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  // core request
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             req_ready,
  // core response
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  // peripheral side
  output logic [NUM_SLAVES-1:0]            slv_sel,
  output logic                             slv_write,
  output logic [ADDR_WIDTH-1:0]            slv_addr,
  output logic [DATA_WIDTH-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]            slv_ack
);

  // Parameter sanity: every slave needs a reachable region index
  if (NUM_SLAVES < 1 || NUM_SLAVES > (2 ** SEL_BITS)) begin : g_chk_slaves
    $error("mmio_bus_decoder: NUM_SLAVES must be in 1..2**SEL_BITS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("mmio_bus_decoder: TIMEOUT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Region decode of the incoming request
  // ---------------------------------------------------------------------
  logic [SEL_BITS-1:0]   dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_mapped;

  mmio_region_decode #(
    .SEL_BITS   (SEL_BITS),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_region_decode (
    .addr_hi_i (req_addr[ADDR_WIDTH-1 -: SEL_BITS]),
    .idx_o     (dec_idx),
    .sel_o     (dec_sel),
    .mapped_o  (dec_mapped)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  mmio_state_e           state_q, state_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic [NUM_SLAVES-1:0] sel_oh_q, sel_oh_d;
  logic                  slv_write_q, slv_write_d;
  logic [ADDR_WIDTH-1:0] slv_addr_q, slv_addr_d;
  logic [DATA_WIDTH-1:0] slv_wdata_q, slv_wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  // Ack and read data of the latched region only; other slaves are ignored
  logic                  ack_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;

  // Mux the selected slave's ack and read-data slice by the latched index
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx_q) == i) begin
        ack_sel   = slv_ack[i];
        rdata_sel = slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef MMIO_DEC_TIMEOUT_EN
  // ---------------------------------------------------------------------
  // ACCESS watchdog: counts ACCESS cycles, cleared when ACCESS is entered
  // ---------------------------------------------------------------------
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  // Final ACCESS cycle without ack expires the transaction
  assign tmo_hit = (state_q == ST_ACCESS) && (tmo_q == TMO_LAST);

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // Next-state logic: accept in IDLE, wait for ack in ACCESS, pulse in RESP
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_oh_d    = sel_oh_q;
    slv_write_d = slv_write_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef MMIO_DEC_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d       = dec_idx;
          sel_oh_d    = dec_sel;
          slv_write_d = req_write;
          slv_addr_d  = req_addr;
          slv_wdata_d = req_wdata;
          if (dec_mapped) begin
            state_d = ST_ACCESS;
`ifdef MMIO_DEC_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            // Unmapped: answer immediately, no peripheral is touched
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
`ifdef MMIO_DEC_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
`endif
        // An ack arriving together with the timeout still wins
        if (ack_sel) begin
          rsp_rdata_d = slv_write_q ? '0 : rdata_sel;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end
`ifdef MMIO_DEC_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      sel_oh_q    <= '0;
      slv_write_q <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_oh_q    <= sel_oh_d;
      slv_write_q <= slv_write_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: handshake flags decoded from state, select only in ACCESS
  // ---------------------------------------------------------------------
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign slv_sel   = (state_q == ST_ACCESS) ? sel_oh_q : '0;
  assign slv_write = slv_write_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;

endmodule : mmio_bus_decoder

// File: tb/tb_mmio_bus_decoder.sv
// Testbench for mmio_bus_decoder: table of transactions with hand-derived
// expectations, a response scoreboard keyed on the expected response
// cycle, and hand sequences for reset, back-to-back and abort cases.
module tb_mmio_bus_decoder;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int SB  = 2;
  localparam int TMO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_write = 1'b0;
  logic [AW-1:0]   req_addr  = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic            req_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [NS-1:0]   slv_sel;
  logic            slv_write;
  logic [AW-1:0]   slv_addr;
  logic [DW-1:0]   slv_wdata;
  logic [NS*DW-1:0] slv_rdata = '0;
  logic [NS-1:0]   slv_ack   = '0;

  always #5 clk = ~clk;

  mmio_bus_decoder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .SEL_BITS(SB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slv_sel(slv_sel), .slv_write(slv_write), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ack(slv_ack)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected response contents and the cycle it must appear in
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            at;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err",   rsp_err,   e.err);
        chk("rsp_cycle", cyc,       e.at);
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] rd, input logic er, input int at);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.at    = at;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_missing: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Transaction vector: stimulus plus hand-derived expectations.
  // wt = wait cycles before ack (-1 = never ack), stray = ack from the
  // other slaves in the first ACCESS cycle.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wt;
    logic [DW-1:0] rd;
    logic          stray;
    logic [NS-1:0] exp_sel;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  task automatic do_txn(input vec_t v);
    logic [SB-1:0] idx;
    int maxk;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    idx = v.addr[AW-1 -: SB];
    for (int i = 0; i < NS; i++)
      slv_rdata[i*DW +: DW] = (i == int'(idx)) ? v.rd : (32'hBAD0_0000 | DW'(i));
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    push_exp(v.exp_rdata, v.exp_err, cyc + v.exp_lat);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = ~v.wr;
    if (v.exp_sel != '0) begin
      maxk = (v.wt < 0) ? TMO - 1 : v.wt;
      for (int k = 0; k <= maxk; k++) begin
        chk("slv_sel_access", slv_sel, v.exp_sel);
        if (k == 0) begin
          chk("slv_addr",  slv_addr,  v.addr);
          chk("slv_write", slv_write, v.wr);
          if (v.wr) chk("slv_wdata", slv_wdata, v.wdata);
        end
        slv_ack = '0;
        if (v.stray && k == 0 && v.wt > 0) slv_ack = ~v.exp_sel;
        if (k == v.wt) slv_ack = v.exp_sel;
        @(negedge clk);
      end
      slv_ack = '0;
    end
    // now in the expected RESP cycle
    chk("slv_sel_resp",   slv_sel,   '0);
    chk("req_ready_resp", req_ready, 1'b0);
    req_valid = 1'b0;
    drain();
  endtask

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    // wr addr wdata wt rd stray | exp_sel exp_rdata exp_err exp_lat
    vecs[0] = '{1'b0, 32'h4000_0010, 32'h0,         0, 32'h0000_00A5, 1'b0, 3'b010, 32'h0000_00A5, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 3, 32'h1111_2222, 1'b0, 3'b001, 32'h0,         1'b0, 5};
    vecs[2] = '{1'b0, 32'hC000_0000, 32'h0,         0, 32'h5555_5555, 1'b0, 3'b000, 32'h0,         1'b1, 1};
    vecs[3] = '{1'b0, 32'h8000_0020, 32'h0,         1, 32'h1234_5678, 1'b0, 3'b100, 32'h1234_5678, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h0000_0100, 32'h0,         2, 32'hCAFE_F00D, 1'b1, 3'b001, 32'hCAFE_F00D, 1'b0, 4};
    vecs[5] = '{1'b1, 32'h4000_0008, 32'h0000_00FF, 0, 32'h7777_7777, 1'b0, 3'b010, 32'h0,         1'b0, 2};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0123_4567, 0, 32'h0,         1'b0, 3'b000, 32'h0,         1'b1, 1};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h0,         4, 32'h0BAD_CAFE, 1'b1, 3'b100, 32'h0BAD_CAFE, 1'b0, 6};

    // Reset held 2 cycles with a request pending
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h4000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_rsp_err",   rsp_err,   1'b0);
    chk("rst_slv_sel",   slv_sel,   '0);
    chk("rst_slv_write", slv_write, 1'b0);
    chk("rst_slv_addr",  slv_addr,  '0);
    chk("rst_slv_wdata", slv_wdata, '0);
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_sel", slv_sel, '0);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) do_txn(vecs[i]);

    // Response data holds while idle
    do_txn(vecs[3]);
    repeat (3) @(negedge clk);
    chk("hold_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("hold_rsp_err",   rsp_err,   1'b0);
    chk("hold_rsp_valid", rsp_valid, 1'b0);

    // req_valid held through RESP: second accept only once back in IDLE
    begin
      int c;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'hC000_0004;
      c = cyc;
      push_exp('0, 1'b1, c + 1);
      push_exp('0, 1'b1, c + 3);
      @(negedge clk);
      chk("held_ready_resp", req_ready, 1'b0);
      @(negedge clk);
      chk("held_ready_idle", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      drain();
    end

    // Reset during ACCESS aborts without a response
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8000_0000;
    slv_ack   = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_sel_a", slv_sel, 3'b100);
    @(negedge clk);
    chk("abort_sel_b", slv_sel, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sel_off",  slv_sel,   '0);
    chk("abort_no_rsp",   rsp_valid, 1'b0);
    chk("abort_ready",    req_ready, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_still_idle", req_ready, 1'b1);

`ifdef MMIO_DEC_TIMEOUT_EN
    begin
      vec_t t;
      // switch never acks: error at T+16
      t = '{1'b0, 32'h8000_0040, 32'h0, -1, 32'h0000_0077, 1'b0, 3'b100, 32'h0, 1'b1, TMO + 1};
      do_txn(t);
      // ack on the 15th ACCESS cycle coincides with the timeout and wins
      t = '{1'b0, 32'h8000_0040, 32'h0, TMO - 1, 32'h0000_0077, 1'b0, 3'b100, 32'h0000_0077, 1'b0, TMO + 1};
      do_txn(t);
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule : tb_mmio_bus_decoder
